// File: rtl/bit_filler_pkg.sv
// Shared types and constants for the bit filler: FSM state encoding and default word width.
package bit_filler_pkg;

    localparam int WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/bit_filler_ctrl.sv
// Control FSM for the bit filler: sequences load, shift-in and completion handshake.
module bit_filler_ctrl
    import bit_filler_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic s,
    input  logic cnt_eq_0,
    output logic Load,
    output logic Shift_In,
    output logic Done,
    output logic busy
);

    state_t ps_r;
    state_t ns_s;
    logic   done_r;
    logic   busy_r;

    // Next-state decode; a fill always runs to completion regardless of s.
    always_comb begin
        ns_s = ps_r;
        case (ps_r)
            S_IDLE: begin
                if (s) ns_s = S_FILL;
                else   ns_s = S_IDLE;
            end
            S_FILL: begin
                if (cnt_eq_0) ns_s = S_DONE;
                else          ns_s = S_FILL;
            end
            S_DONE: begin
                if (s) ns_s = S_DONE;
                else   ns_s = S_IDLE;
            end
            default: ns_s = S_IDLE;
        endcase
    end

    // Datapath strobes: load only while idle with s low, shift only while ones remain.
    always_comb begin
        Load     = 1'b0;
        Shift_In = 1'b0;
        if (ps_r == S_IDLE) begin
            Load = ~s;
        end else if (ps_r == S_FILL) begin
            Shift_In = ~cnt_eq_0;
        end else begin
            Load     = 1'b0;
            Shift_In = 1'b0;
        end
    end

    // State register; status flops track the next state so they equal the state decode.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ps_r   <= S_IDLE;
            done_r <= 1'b0;
            busy_r <= 1'b0;
        end else begin
            ps_r   <= ns_s;
            done_r <= (ns_s == S_DONE);
            busy_r <= (ns_s == S_FILL);
        end
    end

    assign Done = done_r;
    assign busy = busy_r;

endmodule

// File: rtl/bit_filler.sv
// Bit filler top: turns a requested count into a word of that many LSB-justified ones.
module bit_filler
    import bit_filler_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int CW    = $clog2(WIDTH + 1) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s,
    input  logic [CW-1:0]    count_in,
    output logic [WIDTH-1:0] word_out,
    output logic             Done,
    output logic             busy
);

    localparam logic [CW-1:0] WIDTH_CW = CW'(WIDTH);

    logic [CW-1:0]    cnt_r;
    logic [CW-1:0]    cnt_sat_s;
    logic [WIDTH-1:0] word_r;
    logic             cnt_eq_0_s;
    logic             load_s;
    logic             shift_s;

    // Requests beyond the word width saturate to an all-ones word.
    always_comb begin
        cnt_sat_s = count_in;
        if (count_in > WIDTH_CW) cnt_sat_s = WIDTH_CW;
        else                     cnt_sat_s = count_in;
    end

    assign cnt_eq_0_s = (cnt_r == {CW{1'b0}});

    bit_filler_ctrl u_ctrl (
        .clk      (clk),
        .reset    (reset),
        .s        (s),
        .cnt_eq_0 (cnt_eq_0_s),
        .Load     (load_s),
        .Shift_In (shift_s),
        .Done     (Done),
        .busy     (busy)
    );

    // Word and remaining-count registers; shift never runs with cnt at zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r  <= {CW{1'b0}};
            word_r <= {WIDTH{1'b0}};
        end else if (load_s) begin
            cnt_r  <= cnt_sat_s;
            word_r <= {WIDTH{1'b0}};
        end else if (shift_s) begin
            cnt_r  <= cnt_r - CW'(1);
            word_r <= {word_r[WIDTH-2:0], 1'b1};
        end else begin
            cnt_r  <= cnt_r;
            word_r <= word_r;
        end
    end

    assign word_out = word_r;

endmodule

// File: tb/tb_bit_filler.sv
// Self-checking bench for bit_filler (WIDTH=8): behavioural mask model plus per-cycle output checks.
module tb_bit_filler;

    localparam int W  = 8;
    localparam int CW = 5;

    logic          clk;
    logic          reset;
    logic          s;
    logic [CW-1:0] count_in;
    logic [W-1:0]  word_out;
    logic          Done;
    logic          busy;

    int            checks;
    int            errors;
    logic [W-1:0]  exp_mask;
    logic [W-1:0]  got;

    bit_filler #(.WIDTH(W), .CW(CW)) dut (
        .clk      (clk),
        .reset    (reset),
        .s        (s),
        .count_in (count_in),
        .word_out (word_out),
        .Done     (Done),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int sat(input int n);
        return (n > W) ? W : n;
    endfunction

    function automatic logic [W-1:0] model_mask(input int n);
        int m;
        m = (1 << sat(n)) - 1;
        return m[W-1:0];
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // One clock cycle, then the every-cycle comparison against the model on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        if (!reset) begin
            chk("rst_word", int'(word_out), 0);
            chk("rst_done", int'(Done), 0);
            chk("rst_busy", int'(busy), 0);
        end else begin
            chk("done_busy_excl", int'(Done && busy), 0);
            if (Done) chk("word_model", int'(word_out), int'(exp_mask));
        end
    endtask

    // One full handshake: load while idle, raise s, wait for Done, hold, release.
    task automatic run(input int req, input bit scramble, input int hold, output logic [W-1:0] word);
        int  edges;
        int  busy_cnt;
        bit  seen;
        edges    = 0;
        busy_cnt = 0;
        seen     = 1'b0;
        count_in = CW'(req);
        s        = 1'b0;
        tick();
        exp_mask = model_mask(req);
        s        = 1'b1;
        for (int i = 0; i < 60; i++) begin
            tick();
            edges++;
            if (busy) busy_cnt++;
            if (scramble) count_in = CW'($urandom_range(0, 31));
            if (Done) begin
                seen = 1'b1;
                break;
            end
        end
        word = word_out;
        if (!seen) begin
            chk("done_timeout", 0, 1);
        end else begin
            chk("latency", edges, sat(req) + 2);
            chk("busy_cycles", busy_cnt, sat(req) + 1);
            chk("popcount", $countones(word_out), sat(req));
        end
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("hold_done", int'(Done), 1);
            chk("hold_word", int'(word_out), int'(word));
        end
        s = 1'b0;
        tick();
        chk("done_drop", int'(Done), 0);
        chk("idle_busy", int'(busy), 0);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        exp_mask = '0;
        reset    = 1'b0;
        s        = 1'b0;
        count_in = '0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        chk("idle_done", int'(Done), 0);
        chk("idle_busy0", int'(busy), 0);

        // Hand-computed expectations that pin the mask model.
        run(5, 1'b0, 2, got);
        chk("word_k5", int'(got), 32'h1F);
        run(0, 1'b0, 1, got);
        chk("word_k0", int'(got), 32'h00);
        run(12, 1'b0, 1, got);
        chk("word_k12_sat", int'(got), 32'hFF);
        run(3, 1'b1, 1, got);
        chk("word_k3_change", int'(got), 32'h07);

        // Reset in the middle of a fill discards the partial word.
        count_in = CW'(6);
        s        = 1'b0;
        tick();
        exp_mask = model_mask(6);
        s        = 1'b1;
        tick();
        tick();
        tick();
        tick();
        #2 reset = 1'b0;
        #1;
        chk("async_word", int'(word_out), 0);
        chk("async_done", int'(Done), 0);
        chk("async_busy", int'(busy), 0);
        s = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_busy", int'(busy), 0);
            chk("post_rst_done", int'(Done), 0);
        end
        run(2, 1'b0, 1, got);
        chk("word_rerun2", int'(got), 32'h03);

        for (int n = 0; n <= W; n++) begin
            run(n, 1'b0, 0, got);
            chk("sweep_word", int'(got), int'(model_mask(n)));
        end

        for (int i = 0; i < 25; i++) begin
            int req;
            req = int'($urandom_range(0, 31));
            run(req, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), got);
            chk("rand_word", int'(got), int'(model_mask(req)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
